det_count_display: RTL

- Downstream consumer of the sequence detector's z output, clocked by the same divided 1 Hz clock.
- Counts detections as a two-digit BCD value, 00 to 99.
- Drives two active-low seven-segment digits on the DE2 HEX displays.
- Stretches each detection into a visible LED pulse and flags counter overflow.

---
 rtl/det_display_pkg.sv | 19 +
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/det_count_display.sv | 74 +++++++
 3 files changed

// File: rtl/det_display_pkg.sv
// Shared constants for the detection counter display: seven-segment
// patterns (active-low {g,f,e,d,c,b,a}) and the BCD digit limit.
package det_display_pkg;

    localparam logic [3:0] BCD_MAX   = 4'd9;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-low seven-segment decoder.
// Ports: bcd (4-bit digit in), seg (7-bit {g..a}, active-low, out).
module bcd_to_seg7
    import det_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/det_count_display.sv
// Counts detector pulses as two BCD digits (00-99), drives two HEX
// displays, stretches each detection into an LED pulse, flags overflow.
// Ports: clk, rst (async, active-low), clr (sync clear), z (detect in);
// cnt_ones/cnt_tens (BCD), hex0/hex1 (active-low segs), ovf, led.
// Build option: define DETCNT_SAT_EN to saturate at 99 instead of wrapping.
module det_count_display
    import det_display_pkg::*;
#(
    parameter int HOLD_CYCLES = 3,
    parameter int HOLD_W      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       z,
    output logic [3:0] cnt_ones,
    output logic [3:0] cnt_tens,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic       ovf,
    output logic       led
);

    localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(HOLD_CYCLES);

    logic [HOLD_W-1:0] hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_ones <= 4'd0;
            cnt_tens <= 4'd0;
            ovf      <= 1'b0;
            hold     <= '0;
        end else if (clr) begin
            cnt_ones <= 4'd0;
            cnt_tens <= 4'd0;
            ovf      <= 1'b0;
            hold     <= '0;
        end else if (z) begin
            // Retrigger: every detection restarts the full LED window.
            hold <= HOLD_LD;
            if (cnt_ones < BCD_MAX) begin
                cnt_ones <= cnt_ones + 4'd1;
            end else if (cnt_tens < BCD_MAX) begin
                cnt_ones <= 4'd0;
                cnt_tens <= cnt_tens + 4'd1;
            end else begin
                ovf <= 1'b1;
`ifdef DETCNT_SAT_EN
                cnt_ones <= BCD_MAX;
                cnt_tens <= BCD_MAX;
`else
                cnt_ones <= 4'd0;
                cnt_tens <= 4'd0;
`endif
            end
        end else if (hold != '0) begin
            hold <= hold - HOLD_W'(1);
        end
    end

    assign led = (hold != '0);

    bcd_to_seg7 u_seg_ones (
        .bcd (cnt_ones),
        .seg (hex0)
    );

    bcd_to_seg7 u_seg_tens (
        .bcd (cnt_tens),
        .seg (hex1)
    );

endmodule
